riscv_fetch_stage: RTL
======================

RISCV_FETCH_STAGE -- requirements
Module: riscv_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port imem_addr, output, 32, byte address of the current fetch (pc_f).
REQ-005 SHALL have port imem_rd_data, input, 32, instruction word at imem_addr; combinational read.
REQ-006 SHALL have port imem_ready, input, 1, imem_rd_data valid this cycle.
REQ-007 SHALL have port stall_f, input, 1, hazard unit holds pc_f.
REQ-008 SHALL have port stall_d, input, 1, hazard unit holds IF/ID register.
REQ-009 SHALL have port flush_d, input, 1, hazard unit turns IF/ID into a bubble.
REQ-010 SHALL have port redirect, input, 1, taken branch/jump resolved in E.
REQ-011 SHALL have port redirect_pc, input, 32, target of redirect.
REQ-012 SHALL have port instr_d, output, 32, IF/ID instruction.
REQ-013 SHALL have port pc_d, output, 32, IF/ID PC.
REQ-014 SHALL have port pc_plus_4_d, output, 32, IF/ID PC+4.
REQ-015 SHALL have port valid_d, output, 1, instr_d is a real fetched instruction.
REQ-016 SHALL have port misalign_fault, output, 1, sticky misaligned redirect flag.
REQ-017 SHALL have port flush_cnt, output, 16, saturating count of flushed valid instructions.

Function
REQ-018 imem_addr SHALL equal pc_f combinationally.
REQ-019 Next pc_f priority SHALL be: state HALT hold > redirect (load redirect_pc) > stall_f hold > !imem_ready hold > pc_f+4.
REQ-020 redirect SHALL override a simultaneous stall_f.
REQ-021 pc_f+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); pc_plus_4_d likewise.
REQ-022 IF/ID priority SHALL be: flush_d > stall_d hold > (!imem_ready or state HALT) bubble > load {imem_rd_data, pc_f, pc_f+4, valid=1}.
REQ-023 A bubble SHALL be instr_d=32'h0000_0013 (nop), pc_d=0, pc_plus_4_d=0, valid_d=0.
REQ-024 flush_d and stall_d together SHALL produce a bubble.
REQ-025 Latency SHALL be one cycle: word at pc_f appears on instr_d at the next edge when not stalled/flushed.
REQ-026 FSM SHALL have states RUN and HALT; RUN->HALT when redirect=1 and redirect_pc[1:0]!=0; HALT exits only on rst.
REQ-027 On the misaligned redirect edge, pc_f SHALL NOT change, misalign_fault SHALL set to 1 and hold; subsequent IF/ID loads are bubbles.
REQ-028 flush_cnt SHALL increment by 1 on each edge where flush_d=1 and valid_d=1, saturating at 16'hFFFF.
REQ-029 In HALT, redirect, stall_f and imem_ready SHALL be ignored; flush_d still bubbles IF/ID.

Reset
REQ-030 While rst=1: pc_f=RESET_PC, state=RUN, instr_d=nop, pc_d=0, pc_plus_4_d=0, valid_d=0, misalign_fault=0, flush_cnt=0.
REQ-031 Reset mid-operation SHALL discard in-flight IF/ID content; the first fetch after release SHALL be from RESET_PC.

Structure
REQ-032 The NOP constant (32'h0000_0013) and fetch_state_e {RUN, HALT} SHALL live in the shared riscv datapath package/header.
REQ-033 The IF/ID register SHALL be a sub-module if_id_reg (en, clr, d/q bundle); PC, FSM and counter stay in riscv_fetch_stage.

Verification
REQ-034 Reset release, imem_ready=1, no hazards -> imem_addr 0,4,8 on successive cycles; instr_d/pc_d follow one cycle later, valid_d=1.
REQ-035 beq at 0 taken: redirect=1, redirect_pc=0x14, flush_d=1 for one cycle with valid instr in D -> next imem_addr=0x14, instr_d=nop, valid_d=0, flush_cnt=1.
REQ-036 stall_f=stall_d=1 for 2 cycles at pc_f=8 -> imem_addr stays 8, instr_d/pc_d=4 unchanged; resumes 0xC after release.
REQ-037 imem_ready=0 for 1 cycle at pc_f=4 -> pc_f holds 4, instr_d=nop valid_d=0, then word at 4 loaded.
REQ-038 redirect=1, redirect_pc=0x16 -> misalign_fault=1, pc_f unchanged, valid_d=0 thereafter until rst; redirect_pc=0x20 later is ignored.
REQ-039 RESET_PC=0xFFFF_FFFC -> imem_addr 0xFFFF_FFFC then 0x0000_0000; pc_plus_4_d=0 for the first word.

Source files
------------

// File: rtl/riscv_fetch_stage_pkg.sv
// Shared RISC-V datapath types for the fetch stage.
// Holds the NOP encoding, the fetch FSM states and the IF/ID bundle.
package riscv_fetch_stage_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc: 32'h0, pc_plus_4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/riscv_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear wins over enable, and both reset and clear
// produce a bubble.
module if_id_reg
    import riscv_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  logic   clr_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t if_id_q;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= IF_ID_BUBBLE;
        end else if (clr_i) begin
            if_id_q <= IF_ID_BUBBLE;
        end else if (en_i) begin
            if_id_q <= d_i;
        end
    end

    assign q_o = if_id_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT fault FSM, flush counter,
// and the IF/ID register feeding decode.
module riscv_fetch_stage
    import riscv_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_data,
    input  logic        imem_ready,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus_4_d,
    output logic        valid_d,
    output logic        misalign_fault,
    output logic [15:0] flush_cnt
);

    logic [31:0]  pc_f_q, pc_f_d;
    fetch_state_e state_q, state_d;
    logic         fault_q, fault_d;
    logic [15:0]  flush_cnt_q, flush_cnt_d;

    logic [31:0]  pc_plus_4_f;
    logic         misaligned_target;
    if_id_t       if_id_in, if_id_out;

    assign pc_plus_4_f       = pc_f_q + 32'd4;
    assign misaligned_target = (redirect_pc[1:0] != 2'b00);

    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        pc_f_d      = pc_f_q;
        state_d     = state_q;
        fault_d     = fault_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q == RUN) begin
            if (redirect) begin
                // A bad target freezes fetch where it is instead of jumping.
                if (misaligned_target) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else begin
                    pc_f_d = redirect_pc;
                end
            end else if (!stall_f && imem_ready) begin
                pc_f_d = pc_plus_4_f;
            end
        end

        if (flush_d && valid_d && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q      <= RESET_PC;
            state_q     <= RUN;
            fault_q     <= 1'b0;
            flush_cnt_q <= 16'h0000;
        end else begin
            pc_f_q      <= pc_f_d;
            state_q     <= state_d;
            fault_q     <= fault_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        if (imem_ready && (state_q == RUN)) begin
            if_id_in = '{instr: imem_rd_data, pc: pc_f_q, pc_plus_4: pc_plus_4_f, valid: 1'b1};
        end else begin
            if_id_in = IF_ID_BUBBLE;
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (!stall_d),
        .clr_i (flush_d),
        .d_i   (if_id_in),
        .q_o   (if_id_out)
    );

    assign imem_addr      = pc_f_q;
    assign instr_d        = if_id_out.instr;
    assign pc_d           = if_id_out.pc;
    assign pc_plus_4_d    = if_id_out.pc_plus_4;
    assign valid_d        = if_id_out.valid;
    assign misalign_fault = fault_q;
    assign flush_cnt      = flush_cnt_q;

endmodule
